// File: rtl/edge_wait_monitor.sv
// Activity monitor for two control lines: synchronized change/rise detection,
// an armed wait-until-target counter, and a timestamped record FIFO.
module edge_wait_monitor #(
  parameter int unsigned TS_W  = 16,
  parameter int unsigned CTR_W = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             arm,
  input  logic [CTR_W-1:0] target,
  output logic [CTR_W-1:0] ctr_out,
  output logic             busy,
  output logic             wait_done,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_flags,
  output logic [TS_W-1:0]  evt_time,
  output logic             overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RW  = TS_W + 3;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state;
  logic             a_m, a_s, a_p, b_m, b_s, b_p;
  logic [TS_W-1:0]  ts;
  logic [CTR_W-1:0] tgt;
  logic [CTR_W-1:0] ctr_inc;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_n;
  logic [AW:0]      count, remain, cnt_n;
  logic             chg, brise, push, pop, full, push_ok;
  logic [RW-1:0]    rec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_m <= 1'b0; a_s <= 1'b0; a_p <= 1'b0;
      b_m <= 1'b0; b_s <= 1'b0; b_p <= 1'b0;
      ts  <= '0;
    end else begin
      a_m <= a_in; a_s <= a_m; a_p <= a_s;
      b_m <= b_in; b_s <= b_m; b_p <= b_s;
      ts  <= ts + TS_W'(1);
    end
  end

  always_comb begin
    ctr_inc = ctr_out + CTR_W'(1);
    busy    = (state != IDLE);
  end

  // wait_done is registered one edge early so it is high exactly in the hit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctr_out   <= '0;
      tgt       <= '0;
      wait_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arm) begin
          ctr_out   <= '0;
          tgt       <= target;
          wait_done <= (target == '0);
          state     <= COUNT;
        end
        COUNT: if (wait_done) begin
          wait_done <= 1'b0;
          state     <= DONE;
        end else begin
          ctr_out   <= ctr_inc;
          wait_done <= (ctr_inc == tgt);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    chg     = (a_s ^ a_p) | (b_s ^ b_p);
    brise   = b_s & ~b_p;
    push    = chg | brise | wait_done;
    rec     = {wait_done, brise, chg, ts};
    pop     = evt_valid & evt_ready;
    full    = (count == (AW+1)'(DEPTH));
    push_ok = push & (~full | pop);
    remain  = count - (AW+1)'(pop);
    cnt_n   = remain + (AW+1)'(push_ok);
    rd_n    = rd_ptr + AW'(pop);
  end

  // Output registers preload the next head; an empty FIFO bypasses the pushed record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      evt_valid <= 1'b0;
      evt_flags <= '0;
      evt_time  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (push && !push_ok) overflow <= 1'b1;
      rd_ptr    <= rd_n;
      count     <= cnt_n;
      evt_valid <= (cnt_n != '0);
      if (remain == '0) begin
        if (push_ok) {evt_flags, evt_time} <= rec;
      end else begin
        {evt_flags, evt_time} <= mem[rd_n];
      end
    end
  end

endmodule

// File: tb/tb_edge_wait_monitor.sv
// Directed bench for edge_wait_monitor: cycle-indexed pin/arm model plus literal spot checks.
module tb_edge_wait_monitor;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_in = 1'b0, b_in = 1'b0, arm = 1'b0, evt_ready = 1'b1;
  logic [1:0]  target = '0;
  logic [1:0]  ctr_out;
  logic        busy, wait_done, evt_valid, overflow;
  logic [2:0]  evt_flags;
  logic [15:0] evt_time;

  int n_chk = 0;
  int n_fail = 0;

  edge_wait_monitor #(.TS_W(16), .CTR_W(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .arm(arm),
    .target(target), .ctr_out(ctr_out), .busy(busy), .wait_done(wait_done),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_flags(evt_flags),
    .evt_time(evt_time), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Model: e = edges since reset release; pa/pb = pin values sampled at each edge.
  int          e = 0;
  int          pa [0:4095];
  int          pb [0:4095];
  logic [18:0] q [$];
  bit          ovf_m = 0;
  bit          armed = 0;
  int          arm_edge = 0, tgt_m = 0, hit_cyc = -1, busy_until = -1;

  function automatic int pin_a(input int i);
    return (i < 1) ? 0 : pa[i];
  endfunction
  function automatic int pin_b(input int i);
    return (i < 1) ? 0 : pb[i];
  endfunction

  initial forever begin : model
    bit chg, br, wh, pop, full;
    int d;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e = 0; q.delete(); ovf_m = 0; armed = 0; hit_cyc = -1; busy_until = -1;
    end else begin
      e++;
      pa[e] = int'(a_in);
      pb[e] = int'(b_in);
      d = e - 1;
      chg  = (pin_a(d-1) != pin_a(d-2)) || (pin_b(d-1) != pin_b(d-2));
      br   = (pin_b(d-1) == 1) && (pin_b(d-2) == 0);
      wh   = armed && (d == hit_cyc);
      pop  = (q.size() != 0) && evt_ready;
      full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      if (chg || br || wh) begin
        if (!full || pop) q.push_back({wh, br, chg, 16'(d)});
        else ovf_m = 1;
      end
      if (arm && !(armed && d >= arm_edge && d <= busy_until)) begin
        armed = 1; arm_edge = e; tgt_m = int'(target);
        hit_cyc = e + tgt_m; busy_until = e + tgt_m + 1;
      end
    end
  end

  initial forever begin : compare
    int ctr_m;
    bit busy_m, wd_m;
    @(negedge clk);
    #1;
    busy_m = armed && (e >= arm_edge) && (e <= busy_until);
    wd_m   = armed && (e == hit_cyc);
    ctr_m  = !armed ? 0 : ((e - arm_edge) < tgt_m ? (e - arm_edge) : tgt_m);
    chk("m_valid", 32'(evt_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_flags", 32'(evt_flags), 32'(q[0][18:16]));
      chk("m_time", 32'(evt_time), 32'(q[0][15:0]));
    end
    chk("m_ctr", 32'(ctr_out), ctr_m);
    chk("m_busy", 32'(busy), 32'(busy_m));
    chk("m_wait_done", 32'(wait_done), 32'(wd_m));
    chk("m_overflow", 32'(overflow), 32'(ovf_m));
  end

  task automatic at_cycle(input int n);
    int guard = 0;
    while (e != n) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        n_fail++;
        $display("FAIL at_cycle_timeout: cycle %0d, wanted %0d", e, n);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    // Bring-up: quiet lines
    at_cycle(20);
    chk("bringup_ts", 32'(dut.ts), 20);
    chk("bringup_valid", 32'(evt_valid), 0);
    chk("bringup_ctr", 32'(ctr_out), 0);
    chk("bringup_ovf", 32'(overflow), 0);

    do_reset(2);
    at_cycle(10); b_in = 1'b1;
    at_cycle(13);
    chk("brise_valid", 32'(evt_valid), 1);
    chk("brise_flags", 32'(evt_flags), 3'b011);
    chk("brise_time", 32'(evt_time), 12);
    at_cycle(30); b_in = 1'b0;
    at_cycle(33);
    chk("bfall_flags", 32'(evt_flags), 3'b001);
    chk("bfall_time", 32'(evt_time), 32);

    at_cycle(40); a_in = 1'b1; b_in = 1'b1;
    at_cycle(43);
    chk("simul_flags", 32'(evt_flags), 3'b011);
    chk("simul_time", 32'(evt_time), 42);
    at_cycle(44);
    chk("simul_single", 32'(evt_valid), 0);

    at_cycle(50); arm = 1'b1; target = 2'd2;
    at_cycle(51); arm = 1'b0;
    chk("wait_ctr0", 32'(ctr_out), 0);
    at_cycle(52);
    chk("wait_ctr1", 32'(ctr_out), 1);
    chk("wait_nodone", 32'(wait_done), 0);
    arm = 1'b1; target = 2'd0;
    at_cycle(53); arm = 1'b0;
    chk("wait_ctr2", 32'(ctr_out), 2);
    chk("wait_done", 32'(wait_done), 1);
    at_cycle(54);
    chk("wait_flags", 32'(evt_flags), 3'b100);
    chk("wait_time", 32'(evt_time), 53);
    chk("wait_done_off", 32'(wait_done), 0);
    chk("wait_busy_done", 32'(busy), 1);
    at_cycle(55);
    chk("wait_idle", 32'(busy), 0);
    at_cycle(56);
    chk("wait_rearm_ignored", 32'(ctr_out), 2);

    // Backpressure: five changes into a four-deep FIFO, then a push during a full pop
    at_cycle(60); evt_ready = 1'b0; a_in = 1'b0;
    at_cycle(62); a_in = 1'b1;
    at_cycle(64); a_in = 1'b0;
    at_cycle(66); a_in = 1'b1;
    at_cycle(68); a_in = 1'b0;
    at_cycle(72);
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_head", 32'(evt_time), 62);
    at_cycle(73); a_in = 1'b1;
    at_cycle(74);
    chk("bp_hold", 32'(evt_time), 62);
    at_cycle(75); evt_ready = 1'b1;
    chk("drain0_flags", 32'(evt_flags), 3'b001);
    chk("drain0_time", 32'(evt_time), 62);
    at_cycle(76); chk("drain1_time", 32'(evt_time), 64);
    at_cycle(77); chk("drain2_time", 32'(evt_time), 66);
    at_cycle(78); chk("drain3_time", 32'(evt_time), 68);
    at_cycle(79); chk("drain4_time", 32'(evt_time), 75);
    at_cycle(80);
    chk("drain_empty", 32'(evt_valid), 0);
    a_in = 1'b0; b_in = 1'b0;

    // Reset in the middle of a wait
    at_cycle(86); arm = 1'b1; target = 2'd3;
    at_cycle(87); arm = 1'b0;
    at_cycle(88);
    chk("midwait_ctr", 32'(ctr_out), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(wait_done), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ctr", 32'(ctr_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    at_cycle(5);
    chk("post_rst_done", 32'(wait_done), 0);
    chk("post_rst_valid", 32'(evt_valid), 0);

    // target == 0 hits in the first counting cycle
    at_cycle(10); arm = 1'b1; target = 2'd0;
    at_cycle(11); arm = 1'b0;
    chk("t0_done", 32'(wait_done), 1);
    chk("t0_ctr", 32'(ctr_out), 0);
    at_cycle(12);
    chk("t0_flags", 32'(evt_flags), 3'b100);
    chk("t0_time", 32'(evt_time), 11);
    chk("t0_busy", 32'(busy), 1);
    at_cycle(13);
    chk("t0_idle", 32'(busy), 0);
    at_cycle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_wait_monitor.md
Name: edge_wait_monitor

Overview:
Synthesizable activity monitor for two single-bit control lines. It detects any-change and rising edges on those lines, and runs an armed wait-until-counter-equals-target sequence. Each cycle with at least one event produces one timestamped record, which is queued for a downstream reader through a valid/ready FIFO interface. It is the observing end of the delay, event and wait stimulus the team drives onto a/b-style lines. In the team's benches it replaces $display-based monitors.

Parameters:
TS_W, 16, width of the free-running timestamp counter (wraps modulo 2^TS_W).
CTR_W, 2, width of the wait counter and of target.
DEPTH, 4, event FIFO depth in records (power of two, ≥2).

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
a_in  input  1  monitored line a (asynchronous to clk).
b_in  input  1  monitored line b (asynchronous to clk).
arm  input  1  one-cycle pulse: start a wait sequence.
target  input  CTR_W  wait counter value to reach; sampled on arm.
ctr_out  output  CTR_W  current wait counter.
busy  output  1  high while a wait sequence is in progress.
wait_done  output  1  one-cycle pulse when the target is reached.
evt_valid  output  1  FIFO head record is valid.
evt_ready  input  1  reader accepts the head record.
evt_flags  output  3  head record flags {wait_hit, b_rise, change}.
evt_time  output  TS_W  head record timestamp.
overflow  output  1  sticky: a record was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous): all flops 0. This includes the synchronizers, the previous-sample registers, the timestamp, ctr_out, the FSM state (IDLE) and the FIFO pointers. evt_valid=0, busy=0, wait_done=0, overflow=0.
- Input synchronization: a_in and b_in each pass through a 2-flop synchronizer, giving a_s and b_s. Previous-sample registers a_p and b_p follow.
- Edge latency: a change at the pin reaches the record 3 clk edges later. Detection happens after 2 edges, and the push on the next edge.
- change = (a_s^a_p) | (b_s^b_p). b_rise = b_s & ~b_p. If a and b toggle in the same cycle, one record is produced with change=1.
- Timestamp: free-running counter, +1 every cycle from reset, wraps with no flag. A record's evt_time is the timestamp value in its detection cycle.
- Wait FSM:
  - IDLE: when arm=1, load ctr_out=0 and latch target, then go to COUNT.
  - COUNT: ctr_out increments by 1 per cycle, wrapping modulo 2^CTR_W. When ctr_out==latched target, pulse wait_done and set wait_hit in that cycle's flags, then go to DONE.
  - DONE: go to IDLE on the next cycle.
  - target==0: the hit occurs in the first COUNT cycle.
  - busy=1 in COUNT and DONE.
  - arm while busy is ignored.
  - ctr_out holds its value in IDLE and DONE.
- Records: push {wait_hit, b_rise, change, timestamp} in any cycle where any flag is 1.
- FIFO:
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - Push when full with no pop: the record is dropped and overflow sets. overflow clears only on reset.
  - evt_flags and evt_time are held stable while evt_valid=1 and evt_ready=0.
  - Output data is registered from FIFO storage. When the FIFO is empty, a pushed record appears at the outputs the following cycle.
- Reset mid-operation: the sequence is aborted, the FIFO is flushed, and no wait_done is emitted.

Test Plan:
- Bring-up: reset, release, hold a_in=b_in=0 for 20 cycles -> evt_valid=0, ctr_out=0, overflow=0, timestamp=20 at cycle 20.
- Edge capture: raise b_in at the cycle-10 edge, keep evt_ready=1 -> one record, flags=3'b011, evt_time=12. Drop b_in at cycle 30 -> flags=3'b001, evt_time=32.
- Simultaneous change: toggle a_in and b_in 0->1 on the same edge -> exactly one record, flags=3'b011.
- Wait sequence: pulse arm with target=2 at cycle 50 -> ctr_out reads 0,1,2 in cycles 51..53, wait_done=1 in cycle 53 only, record flags=3'b100, busy=0 from cycle 55. A second arm in cycle 52 has no effect.
- Backpressure/overflow: hold evt_ready=0 and generate 5 change events (DEPTH=4) -> 4 records retained in order, overflow=1. Then assert evt_ready -> the 4 records drain in 4 cycles with timestamps unchanged.
- Reset mid-wait: arm with target=3, assert rst_n low for 1 cycle after 1 count -> no wait_done, busy=0, FIFO empty, overflow=0.
